// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
//
// Display-side reader for a double-buffered, upscaled RGB565 frame buffer. Converts the
// video timing position into a BRAM read address, expands the returned RGB565 word to
// RGB888 and delays the sync/active strobes so they line up with the pixel data.
// A small handshake FSM swaps the displayed buffer only at new-frame boundaries.
//
// Optional feature: define FB_READER_BORDER_EN to paint a one-pixel white border around
// the active area (same latency as buffer data). Without the macro no border logic exists.
//
// Ports:
//   pixel_clk_in     pixel clock
//   rst_in           synchronous active-high reset
//   hcount_in        horizontal position from the timing generator
//   vcount_in        vertical position from the timing generator
//   hs_in, vs_in     horizontal / vertical sync from the timing generator
//   ad_in            active-display flag
//   nf_in            new-frame strobe
//   addr_out         BRAM read address (registered)
//   bram_data_in     RGB565 read data, valid BRAM_LATENCY cycles after addr_out
//   swap_req_in      writer requests a buffer swap
//   swap_ack_out     one-cycle swap grant
//   read_buf_out     buffer currently being displayed
//   rgb_out          {R8,G8,B8}, BRAM_LATENCY+2 cycles after the timing inputs
//   hs_out, vs_out,
//   ad_out           timing strobes delayed to align with rgb_out
//   frame_count_out  6-bit wrapping frame counter

module frame_buffer_reader #(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned SCALE_SHIFT     = 2,
  parameter int unsigned BRAM_LATENCY    = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        ad_in,
  input  logic        nf_in,
  output logic [16:0] addr_out,
  input  logic [15:0] bram_data_in,
  input  logic        swap_req_in,
  output logic        swap_ack_out,
  output logic        read_buf_out,
  output logic [23:0] rgb_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic [5:0]  frame_count_out
);

  localparam int unsigned FbW       = ACTIVE_H_PIXELS >> SCALE_SHIFT;
  localparam int unsigned FbH       = ACTIVE_LINES >> SCALE_SHIFT;
  localparam int unsigned FbSize    = FbW * FbH;
  // One cycle to register the address, BRAM_LATENCY in the BRAM, one to register rgb_out.
  localparam int unsigned PipeDepth = BRAM_LATENCY + 2;

  // ------------------------------------------------------------------------------------
  // Address generation
  // ------------------------------------------------------------------------------------
  logic [16:0] col;
  logic [16:0] row;
  logic [16:0] row_base;
  logic [16:0] buf_base;
  logic [16:0] addr_d;

  always_comb begin
    col      = 17'(hcount_in >> SCALE_SHIFT);
    row      = 17'(vcount_in >> SCALE_SHIFT);
    row_base = row * 17'(FbW);
    buf_base = read_buf_out ? 17'(FbSize) : 17'd0;
    // Park the address at 0 outside active video so no stray reads are issued.
    addr_d   = ad_in ? (buf_base + row_base + col) : 17'd0;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      addr_out <= 17'd0;
    end else begin
      addr_out <= addr_d;
    end
  end

  // ------------------------------------------------------------------------------------
  // Timing strobe delay lines; bit k holds the input delayed by k+1 cycles
  // ------------------------------------------------------------------------------------
  logic [PipeDepth-1:0] hs_pipe;
  logic [PipeDepth-1:0] vs_pipe;
  logic [PipeDepth-1:0] ad_pipe;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
      ad_pipe <= '0;
    end else begin
      hs_pipe <= {hs_pipe[PipeDepth-2:0], hs_in};
      vs_pipe <= {vs_pipe[PipeDepth-2:0], vs_in};
      ad_pipe <= {ad_pipe[PipeDepth-2:0], ad_in};
    end
  end

  assign hs_out = hs_pipe[PipeDepth-1];
  assign vs_out = vs_pipe[PipeDepth-1];
  assign ad_out = ad_pipe[PipeDepth-1];

  // ------------------------------------------------------------------------------------
  // Optional border overlay, carried alongside the strobes
  // ------------------------------------------------------------------------------------
`ifdef FB_READER_BORDER_EN
  logic                 border_in;
  logic [PipeDepth-2:0] bd_pipe;

  always_comb begin
    border_in = ad_in && ((hcount_in == 11'd0) ||
                          (hcount_in == 11'(ACTIVE_H_PIXELS - 1)) ||
                          (vcount_in == 10'd0) ||
                          (vcount_in == 10'(ACTIVE_LINES - 1)));
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      bd_pipe <= '0;
    end else begin
      bd_pipe <= {bd_pipe[PipeDepth-3:0], border_in};
    end
  end
`endif

  // ------------------------------------------------------------------------------------
  // Pixel expansion; stage PipeDepth-2 of the strobes is aligned with bram_data_in
  // ------------------------------------------------------------------------------------
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [23:0] rgb_exp;
  logic [23:0] rgb_d;

  always_comb begin
    r5      = bram_data_in[15:11];
    g6      = bram_data_in[10:5];
    b5      = bram_data_in[4:0];
    // Replicate MSBs into the new LSBs so full-scale 565 maps to full-scale 888.
    rgb_exp = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    rgb_d   = 24'd0;
    if (ad_pipe[PipeDepth-2]) begin
`ifdef FB_READER_BORDER_EN
      rgb_d = bd_pipe[PipeDepth-2] ? 24'hFFFFFF : rgb_exp;
`else
      rgb_d = rgb_exp;
`endif
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rgb_out <= 24'd0;
    end else begin
      rgb_out <= rgb_d;
    end
  end

  // ------------------------------------------------------------------------------------
  // Buffer swap handshake and frame counter
  // ------------------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StPending} swap_state_e;

  swap_state_e state_q;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q         <= StIdle;
      read_buf_out    <= 1'b0;
      swap_ack_out    <= 1'b0;
      frame_count_out <= 6'd0;
    end else begin
      swap_ack_out <= 1'b0;
      if (nf_in) begin
        frame_count_out <= frame_count_out + 6'd1;
      end
      // read_buf only ever flips on nf_in, so a frame never mixes buffers. After a grant
      // the FSM returns to idle; a request still held re-arms for the next frame.
      case (state_q)
        StIdle: begin
          if (swap_req_in) begin
            if (nf_in) begin
              read_buf_out <= ~read_buf_out;
              swap_ack_out <= 1'b1;
            end else begin
              state_q <= StPending;
            end
          end
        end
        StPending: begin
          if (nf_in) begin
            read_buf_out <= ~read_buf_out;
            swap_ack_out <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
